// File: rtl/nrisc_int_pkg.sv
// Shared definitions for the NRISC interrupt vector controller:
// command encodings on CORE_INT_ctrl, the mask-register select code and the
// offer FSM state type.
package nrisc_int_pkg;

  localparam logic [1:0] INT_IDLE = 2'b00;
  localparam logic [1:0] INT_ACK  = 2'b01;
  localparam logic [1:0] INT_WR   = 2'b10;
  localparam logic [1:0] INT_RET  = 2'b11;

  // CORE_INT_CHA value that addresses the mask register instead of a vector.
  localparam logic [7:0] INT_MASK_SEL = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } int_state_t;

endpackage

// File: rtl/nrisc_int_prio_enc.sv
// Lowest-set-bit finder. Bit 0 has the highest priority, so this yields
// both the interrupt winner and the most recently entered in-service level.
module nrisc_int_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] bits,
  output logic         valid,
  output logic [7:0]   idx
);

  // Scan downwards so the lowest set bit is the last assignment that sticks.
  always_comb begin
    valid = |bits;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) idx = 8'(i);
    end
  end

endmodule

// File: rtl/nrisc_int_vector.sv
// Interrupt vector controller for the NRISC core.
// Captures rising edges on INT_irq, applies mask, in-service blocking and a
// fixed priority (channel 0 highest), offers the winner with its programmed
// vector, and tracks in-service channels until the matching return.
// Build option: define NRISC_INT_NESTING_EN to let strictly higher-priority
// channels preempt a channel that is in service.
module nrisc_int_vector
  import nrisc_int_pkg::*;
#(
  parameter int TAM = 16,
  parameter int NCH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] INT_irq,
  input  logic [1:0]     CORE_INT_ctrl,
  input  logic [7:0]     CORE_INT_CHA,
  input  logic [TAM-1:0] INT_DATA_in,
  output logic           INT_request,
  output logic [7:0]     INT_channel,
  output logic [TAM-1:0] INT_vector,
  output logic [NCH-1:0] INT_in_service
);

  logic [NCH-1:0] prev;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] in_service;
  logic [TAM-1:0] vec [NCH];

  int_state_t state_reg, state_next;

  logic [NCH-1:0] edge_det, blocked, eligible, ack_clear, ret_clear;
  logic           win_valid, is_valid;
  logic [7:0]     win_idx, is_idx;
  logic           ack_ok, ret_ok, wr_en;
  logic [TAM-1:0] vec_sel;

  logic           request_reg, request_next;
  logic [7:0]     channel_reg, channel_next;
  logic [TAM-1:0] vector_reg, vector_next;

  assign edge_det = INT_irq & ~prev;
  assign eligible = pending & mask & ~blocked;
  assign wr_en    = (CORE_INT_ctrl == INT_WR);
  // An ack only counts while something is actually being offered.
  assign ack_ok   = (state_reg == ST_OFFER) && (CORE_INT_ctrl == INT_ACK) && win_valid;
  assign ret_ok   = (CORE_INT_ctrl == INT_RET) && is_valid;

  nrisc_int_prio_enc #(.N(NCH)) u_win (
    .bits  (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  nrisc_int_prio_enc #(.N(NCH)) u_isv (
    .bits  (in_service),
    .valid (is_valid),
    .idx   (is_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
`ifdef NRISC_INT_NESTING_EN
      // Only channels strictly above the active level may interrupt it.
      assign blocked[gi] = is_valid && (is_idx <= 8'(gi));
`else
      assign blocked[gi] = is_valid;
`endif
      assign ack_clear[gi] = ack_ok && (win_idx == 8'(gi));
      assign ret_clear[gi] = ret_ok && (is_idx == 8'(gi));
    end
  endgenerate

  // Select the vector of the current winner for the registered output.
  always_comb begin
    vec_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win_idx == 8'(i)) vec_sel = vec[i];
    end
  end

  // Edge capture, mask writes and in-service tracking; a new edge wins over
  // the ack clearing the same pending bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      pending    <= '0;
      mask       <= '0;
      in_service <= '0;
    end else begin
      prev       <= INT_irq;
      pending    <= (pending & ~ack_clear) | edge_det;
      in_service <= (in_service & ~ret_clear) | ack_clear;
      if (wr_en && (CORE_INT_CHA == INT_MASK_SEL)) mask <= INT_DATA_in[NCH-1:0];
    end
  end

  // Per-channel vector table, written by the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) vec[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_en && (CORE_INT_CHA == 8'(i))) vec[i] <= INT_DATA_in;
      end
    end
  end

  // Offer FSM next state and next values of the registered outputs.
  always_comb begin
    state_next   = state_reg;
    request_next = 1'b0;
    channel_next = channel_reg;
    vector_next  = vector_reg;
    case (state_reg)
      ST_IDLE:  if (win_valid) state_next = ST_OFFER;
      ST_OFFER: if (ack_ok || !win_valid) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (state_next == ST_OFFER) begin
      request_next = 1'b1;
      channel_next = win_idx;
      vector_next  = vec_sel;
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      request_reg <= 1'b0;
      channel_reg <= '0;
      vector_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      request_reg <= request_next;
      channel_reg <= channel_next;
      vector_reg  <= vector_next;
    end
  end

  assign INT_request    = request_reg;
  assign INT_channel    = channel_reg;
  assign INT_vector     = vector_reg;
  assign INT_in_service = in_service;

endmodule

// File: tb/tb_nrisc_int_vector.sv
// Table-driven bench for nrisc_int_vector. Each table row is one clock of
// stimulus followed by the outputs expected just after that edge.
// Expectations for the preemption sequence follow NRISC_INT_NESTING_EN.
module tb_nrisc_int_vector;
  import nrisc_int_pkg::*;

  localparam int TAM = 16;
  localparam int NCH = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] irq = '0;
  logic [1:0]     ctrl = INT_IDLE;
  logic [7:0]     cha = '0;
  logic [TAM-1:0] din = '0;
  logic           req;
  logic [7:0]     ch;
  logic [TAM-1:0] vec;
  logic [NCH-1:0] isv;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  irq;
    logic [1:0]  ctrl;
    logic [7:0]  cha;
    logic [15:0] data;
    logic        req;
    logic [7:0]  ch;
    logic [15:0] vec;
    logic [7:0]  isv;
  } row_t;

  row_t tbl[$];

  nrisc_int_vector #(.TAM(TAM), .NCH(NCH)) dut (
    .clk            (clk),
    .rst            (rst),
    .INT_irq        (irq),
    .CORE_INT_ctrl  (ctrl),
    .CORE_INT_CHA   (cha),
    .INT_DATA_in    (din),
    .INT_request    (req),
    .INT_channel    (ch),
    .INT_vector     (vec),
    .INT_in_service (isv)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(logic [7:0] i, logic [1:0] c, logic [7:0] a, logic [15:0] d,
                              logic r, logic [7:0] ec, logic [15:0] ev, logic [7:0] es);
    row_t t;
    t.irq = i; t.ctrl = c; t.cha = a; t.data = d;
    t.req = r; t.ch = ec; t.vec = ev; t.isv = es;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Basic flow: mask ch0, vector 0x0040, edge, offer, ack, return.
    tbl.push_back(mk(8'h00, INT_WR,   8'hFF, 16'h0001, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_WR,   8'h00, 16'h0040, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h01, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 0, 16'h0040, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 0, 16'h0040, 8'h00));
    tbl.push_back(mk(8'h00, INT_ACK,  8'h00, 16'h0000, 0, 0, 0, 8'h01));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h01));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h00));
    // Masking: edge on masked ch3 stays pending, offered after unmask;
    // vector rewrite while offered shows one cycle later.
    tbl.push_back(mk(8'h00, INT_WR,   8'hFF, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_WR,   8'h03, 16'h0123, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h08, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_WR,   8'hFF, 16'h0008, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 3, 16'h0123, 8'h00));
    tbl.push_back(mk(8'h00, INT_WR,   8'h03, 16'h0456, 1, 3, 16'h0123, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 3, 16'h0456, 8'h00));
    tbl.push_back(mk(8'h00, INT_ACK,  8'h00, 16'h0000, 0, 0, 0, 8'h08));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
    // Priority: ch2 and ch5 together, ch2 first, ch5 after its return.
    tbl.push_back(mk(8'h00, INT_WR,   8'hFF, 16'h00FF, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_WR,   8'h02, 16'h0200, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_WR,   8'h05, 16'h0500, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h24, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 2, 16'h0200, 8'h00));
    tbl.push_back(mk(8'h00, INT_ACK,  8'h00, 16'h0000, 0, 0, 0, 8'h04));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h04));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 5, 16'h0500, 8'h00));
    tbl.push_back(mk(8'h00, INT_ACK,  8'h00, 16'h0000, 0, 0, 0, 8'h20));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
    // Nesting: ch4 in service, then irq[1].
    tbl.push_back(mk(8'h00, INT_WR,   8'h04, 16'h0400, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_WR,   8'h01, 16'h0100, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h10, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 4, 16'h0400, 8'h00));
    tbl.push_back(mk(8'h00, INT_ACK,  8'h00, 16'h0000, 0, 0, 0, 8'h10));
    tbl.push_back(mk(8'h02, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h10));
`ifdef NRISC_INT_NESTING_EN
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 1, 16'h0100, 8'h10));
    tbl.push_back(mk(8'h00, INT_ACK,  8'h00, 16'h0000, 0, 0, 0, 8'h12));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h10));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h10));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
`else
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h10));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h10));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 1, 16'h0100, 8'h00));
    tbl.push_back(mk(8'h00, INT_ACK,  8'h00, 16'h0000, 0, 0, 0, 8'h02));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
`endif
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h00));
    // New ch0 edge in the ack cycle keeps pending; re-offered after return.
    tbl.push_back(mk(8'h01, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 0, 16'h0040, 8'h00));
    tbl.push_back(mk(8'h01, INT_ACK,  8'h00, 16'h0000, 0, 0, 0, 8'h01));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h01));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 0, 16'h0040, 8'h00));
    tbl.push_back(mk(8'h00, INT_ACK,  8'h00, 16'h0000, 0, 0, 0, 8'h01));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
    // Ack in IDLE and return with nothing in service change nothing.
    tbl.push_back(mk(8'h00, INT_WR,   8'hFF, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h80, INT_IDLE, 8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_ACK,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_RET,  8'h00, 16'h0000, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_WR,   8'h07, 16'h0700, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_WR,   8'hFF, 16'h00FF, 0, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 7, 16'h0700, 8'h00));
    tbl.push_back(mk(8'h00, INT_IDLE, 8'h00, 16'h0000, 1, 7, 16'h0700, 8'h00));

    // Reset state.
    repeat (3) tick();
    check("reset req", 32'(req), 32'h0);
    check("reset ch",  32'(ch),  32'h0);
    check("reset vec", 32'(vec), 32'h0);
    check("reset isv", 32'(isv), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      irq  = tbl[i].irq;
      ctrl = tbl[i].ctrl;
      cha  = tbl[i].cha;
      din  = tbl[i].data;
      tick();
      $display("row %0d irq=%h ctrl=%b cha=%h data=%h -> req=%b ch=%0d vec=%h isv=%h",
               i, tbl[i].irq, tbl[i].ctrl, tbl[i].cha, tbl[i].data, req, ch, vec, isv);
      check($sformatf("row%0d req", i), 32'(req), 32'(tbl[i].req));
      check($sformatf("row%0d isv", i), 32'(isv), 32'(tbl[i].isv));
      if (tbl[i].req) begin
        check($sformatf("row%0d ch", i),  32'(ch),  32'(tbl[i].ch));
        check($sformatf("row%0d vec", i), 32'(vec), 32'(tbl[i].vec));
      end
    end

    // Reset while offering ch7: outputs clear next cycle, pending discarded.
    irq = '0; ctrl = INT_IDLE; cha = '0; din = '0;
    rst = 1'b1;
    tick();
    $display("reset in OFFER -> req=%b ch=%0d vec=%h isv=%h", req, ch, vec, isv);
    check("rst offer req", 32'(req), 32'h0);
    check("rst offer ch",  32'(ch),  32'h0);
    check("rst offer vec", 32'(vec), 32'h0);
    check("rst offer isv", 32'(isv), 32'h0);
    rst  = 1'b0;
    ctrl = INT_WR; cha = INT_MASK_SEL; din = 16'h00FF;
    tick();
    ctrl = INT_IDLE; cha = '0; din = '0;
    repeat (2) tick();
    $display("after reset, mask=FF -> req=%b isv=%h", req, isv);
    check("rst pending gone", 32'(req), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
